// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline hazard controller signal bundle
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_RS1_i;
    logic [4:0]       IF_ID_RS2_i;
    logic [4:0]       ID_EX_RD_i;
    logic             ID_EX_MemRead_i;
    logic             Branch_i;
    logic             BranchTaken_i;
    logic             EX_MEM_MemRead_i;
    logic             EX_MEM_MemWrite_i;
    logic             MemReady_i;
    logic             NoOp_o;
    logic             PCWrite_o;
    logic             Stall_o;
    logic             Freeze_o;
    logic             Flush_o;
    logic             MemTimeout_o;
    logic [CNT_W-1:0] BubbleCnt_o;
    logic [CNT_W-1:0] FreezeCnt_o;

    modport master (
        output IF_ID_RS1_i, IF_ID_RS2_i, ID_EX_RD_i, ID_EX_MemRead_i,
               Branch_i, BranchTaken_i, EX_MEM_MemRead_i, EX_MEM_MemWrite_i,
               MemReady_i,
        input  NoOp_o, PCWrite_o, Stall_o, Freeze_o, Flush_o,
               MemTimeout_o, BubbleCnt_o, FreezeCnt_o
    );

    modport slave (
        input  IF_ID_RS1_i, IF_ID_RS2_i, ID_EX_RD_i, ID_EX_MemRead_i,
               Branch_i, BranchTaken_i, EX_MEM_MemRead_i, EX_MEM_MemWrite_i,
               MemReady_i,
        output NoOp_o, PCWrite_o, Stall_o, Freeze_o, Flush_o,
               MemTimeout_o, BubbleCnt_o, FreezeCnt_o
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use bubble, branch flush and memory-wait freeze control
module hazard_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_unit_if.slave  bus
);
    typedef enum logic {RUN, WAIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    logic memacc, loaduse, taken, freeze;
    logic noop, pcwrite, stall, flush;

    assign memacc  = bus.EX_MEM_MemRead_i | bus.EX_MEM_MemWrite_i;
    assign loaduse = bus.ID_EX_MemRead_i && (bus.ID_EX_RD_i != 5'd0) &&
                     ((bus.ID_EX_RD_i == bus.IF_ID_RS1_i) ||
                      (bus.ID_EX_RD_i == bus.IF_ID_RS2_i));
    assign taken   = bus.Branch_i & bus.BranchTaken_i;

    // Freeze decision and wait-counter next state share the same conditions.
    always_comb begin
        freeze    = 1'b0;
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        if (state_q == RUN) begin
            if (memacc && !bus.MemReady_i) begin
                freeze  = 1'b1;
                wcnt_d  = 8'd1;
                state_d = WAIT;
            end
        end else begin
            if (bus.MemReady_i) begin
                wcnt_d  = 8'd0;
                state_d = RUN;
            end else if (wcnt_q == 8'(MAX_WAIT)) begin
                timeout_d = 1'b1;
                wcnt_d    = 8'd0;
                state_d   = RUN;
            end else begin
                freeze = 1'b1;
                wcnt_d = wcnt_q + 8'd1;
            end
        end
        if (rst_i) begin
            freeze = 1'b0;
        end
    end

    always_comb begin
        noop    = 1'b0;
        pcwrite = 1'b1;
        stall   = 1'b0;
        flush   = 1'b0;
        if (rst_i) begin
            pcwrite = 1'b1;
        end else if (freeze) begin
            pcwrite = 1'b0;
            stall   = 1'b1;
        end else if (loaduse) begin
            noop    = 1'b1;
            stall   = 1'b1;
            pcwrite = 1'b0;
        end else if (taken) begin
            flush   = 1'b1;
        end
    end

    always_comb begin
        bubble_d     = bubble_q;
        freeze_cnt_d = freeze_cnt_q;
        if (noop && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
        if (freeze && (freeze_cnt_q != '1)) begin
            freeze_cnt_d = freeze_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            wcnt_q       <= 8'd0;
            timeout_q    <= 1'b0;
            bubble_q     <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            timeout_q    <= timeout_d;
            bubble_q     <= bubble_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign bus.NoOp_o       = noop;
    assign bus.PCWrite_o    = pcwrite;
    assign bus.Stall_o      = stall;
    assign bus.Freeze_o     = freeze;
    assign bus.Flush_o      = flush;
    assign bus.MemTimeout_o = timeout_q;
    assign bus.BubbleCnt_o  = bubble_q;
    assign bus.FreezeCnt_o  = freeze_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;
    localparam int CNT_W    = 3;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IF_ID_RS1_i       = 5'd0;
        bus.IF_ID_RS2_i       = 5'd0;
        bus.ID_EX_RD_i        = 5'd0;
        bus.ID_EX_MemRead_i   = 1'b0;
        bus.Branch_i          = 1'b0;
        bus.BranchTaken_i     = 1'b0;
        bus.EX_MEM_MemRead_i  = 1'b0;
        bus.EX_MEM_MemWrite_i = 1'b0;
        bus.MemReady_i        = 1'b0;
    endtask

    task automatic set_loaduse();
        bus.ID_EX_MemRead_i = 1'b1;
        bus.ID_EX_RD_i      = 5'd5;
        bus.IF_ID_RS2_i     = 5'd5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        set_loaduse();
        #1;
        check("rst_noop",    32'(bus.NoOp_o),    0);
        check("rst_pcwrite", 32'(bus.PCWrite_o), 1);
        check("rst_stall",   32'(bus.Stall_o),   0);
        step();
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst_bubblecnt", 32'(bus.BubbleCnt_o),  0);
        check("rst_freezecnt", 32'(bus.FreezeCnt_o),  0);
        check("rst_timeout",   32'(bus.MemTimeout_o), 0);

        // load-use on rs2
        set_loaduse();
        #1;
        check("lu_noop",    32'(bus.NoOp_o),    1);
        check("lu_pcwrite", 32'(bus.PCWrite_o), 0);
        check("lu_stall",   32'(bus.Stall_o),   1);
        check("lu_freeze",  32'(bus.Freeze_o),  0);
        step();
        idle_inputs();
        #1;
        check("lu_bubblecnt", 32'(bus.BubbleCnt_o), 1);
        check("lu_after_noop", 32'(bus.NoOp_o), 0);
        bus.ID_EX_MemRead_i = 1'b1;
        #1;
        check("lu_rd0_noop",    32'(bus.NoOp_o),    0);
        check("lu_rd0_pcwrite", 32'(bus.PCWrite_o), 1);
        step();
        check("lu_rd0_cnt", 32'(bus.BubbleCnt_o), 1);

        // memory miss of 3 cycles then ready
        idle_inputs();
        bus.EX_MEM_MemRead_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("miss_freeze%0d", i), 32'(bus.Freeze_o), 1);
            check($sformatf("miss_pcw%0d", i),    32'(bus.PCWrite_o), 0);
            step();
        end
        bus.MemReady_i = 1'b1;
        #1;
        check("miss_ready_freeze", 32'(bus.Freeze_o), 0);
        step();
        check("miss_freezecnt", 32'(bus.FreezeCnt_o), 3);
        check("hit_same_cycle", 32'(bus.Freeze_o), 0);
        bus.EX_MEM_MemRead_i  = 1'b0;
        bus.EX_MEM_MemWrite_i = 1'b1;
        bus.MemReady_i        = 1'b0;
        #1;
        check("b2b_store_freeze", 32'(bus.Freeze_o), 1);
        step();
        bus.MemReady_i = 1'b1;
        step();
        check("b2b_freezecnt", 32'(bus.FreezeCnt_o), 4);

        // timeout: MAX_WAIT freeze cycles then one unfrozen cycle
        idle_inputs();
        do_reset();
        bus.EX_MEM_MemRead_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("to_freeze%0d", i), 32'(bus.Freeze_o), (i < MAX_WAIT) ? 1 : 0);
            check($sformatf("to_flag%0d", i), 32'(bus.MemTimeout_o), 0);
            step();
        end
        check("to_flag_set",   32'(bus.MemTimeout_o), 1);
        check("to_freezecnt",  32'(bus.FreezeCnt_o), MAX_WAIT);
        idle_inputs();
        step();
        check("to_flag_sticky", 32'(bus.MemTimeout_o), 1);

        // priority: freeze beats load-use beats taken branch
        bus.EX_MEM_MemRead_i = 1'b1;
        set_loaduse();
        bus.Branch_i      = 1'b1;
        bus.BranchTaken_i = 1'b1;
        #1;
        check("pri_f_freeze", 32'(bus.Freeze_o), 1);
        check("pri_f_noop",   32'(bus.NoOp_o),   0);
        check("pri_f_flush",  32'(bus.Flush_o),  0);
        step();
        bus.MemReady_i = 1'b1;
        #1;
        check("pri_lu_freeze",  32'(bus.Freeze_o),  0);
        check("pri_lu_noop",    32'(bus.NoOp_o),    1);
        check("pri_lu_flush",   32'(bus.Flush_o),   0);
        check("pri_lu_pcwrite", 32'(bus.PCWrite_o), 0);
        step();
        bus.EX_MEM_MemRead_i = 1'b0;
        bus.ID_EX_MemRead_i  = 1'b0;
        #1;
        check("pri_br_flush",   32'(bus.Flush_o),   1);
        check("pri_br_pcwrite", 32'(bus.PCWrite_o), 1);
        check("pri_br_stall",   32'(bus.Stall_o),   0);
        check("pri_br_noop",    32'(bus.NoOp_o),    0);
        bus.BranchTaken_i = 1'b0;
        #1;
        check("pri_nt_flush", 32'(bus.Flush_o), 0);
        step();

        // reset while waiting on memory
        idle_inputs();
        do_reset();
        bus.EX_MEM_MemRead_i = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rstw_freeze_in_rst", 32'(bus.Freeze_o), 0);
        step();
        rst = 1'b0;
        bus.EX_MEM_MemRead_i = 1'b0;
        #1;
        check("rstw_freeze",    32'(bus.Freeze_o),     0);
        check("rstw_freezecnt", 32'(bus.FreezeCnt_o),  0);
        check("rstw_timeout",   32'(bus.MemTimeout_o), 0);
        check("rstw_bubble",    32'(bus.BubbleCnt_o),  0);

        // bubble counter saturation
        do_reset();
        set_loaduse();
        bus.IF_ID_RS2_i = 5'd0;
        bus.IF_ID_RS1_i = 5'd5;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("sat_noop%0d", i), 32'(bus.NoOp_o), 1);
            step();
            check($sformatf("sat_cnt%0d", i), 32'(bus.BubbleCnt_o), (i + 1 < 7) ? i + 1 : 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
